// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button event generator: state encoding,
// default threshold constants and the counter-width helper.
package button_event_gen_pkg;

    // State encoding of the press/hold tracker (2-bit)
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    // Simulation-friendly defaults
    localparam int LONG_COUNT_SIM   = 20;
    localparam int REPEAT_COUNT_SIM = 8;

    // Silicon values at 50 MHz: 5 s long hold, 0.5 s repeat period
    localparam int LONG_COUNT_SYN   = 250_000_000;
    localparam int REPEAT_COUNT_SYN = 25_000_000;

    // Counter width large enough for the larger of the two terminal counts
    function automatic int cnt_width(input int long_count, input int repeat_count);
        int max_count;
        max_count = (long_count > repeat_count) ? long_count : repeat_count;
        return $clog2(max_count);
    endfunction

endpackage

// File: rtl/button_event_gen_edge_detect.sv
// Press-edge detector: keeps the previous button sample and flags the
// released-to-pressed transition (active-low button).
module button_event_gen_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press_edge
);

    logic btn_q_r;

    // Previous sample; reset loads "released" so a button held through reset produces a press
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q_r <= 1'b1;
        end else begin
            btn_q_r <= btn_n;
        end
    end

    assign press_edge = (~btn_n) & btn_q_r;

endmodule

// File: rtl/button_event_gen.sv
// Button event generator: turns a debounced active-low button level into
// one-cycle press / short-release / long-hold events plus a hold level.
// Optional feature macro: BUTTON_REPEAT_EN enables periodic repeat_pulse
// while the button stays in the long-hold state; without it repeat_pulse
// is constant 0 and the hold counter simply saturates.
module button_event_gen
    import button_event_gen_pkg::*;
#(
    parameter int LONG_COUNT   = LONG_COUNT_SIM,
    parameter int REPEAT_COUNT = REPEAT_COUNT_SIM
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic hold_level,
    output logic repeat_pulse
);

    localparam int CNT_W = cnt_width(LONG_COUNT, REPEAT_COUNT);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);
`else
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
`endif

    logic             press_edge_s;
    btn_state_t       state_r;
    btn_state_t       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             press_r;
    logic             press_nxt_s;
    logic             short_r;
    logic             short_nxt_s;
    logic             long_r;
    logic             long_nxt_s;
    logic             hold_r;
    logic             hold_nxt_s;
    logic             repeat_r;
    logic             repeat_nxt_s;

    button_event_gen_edge_detect u_edge_detect (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .press_edge (press_edge_s)
    );

    // Next-state, counter and event decode; release always wins over a threshold hit
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        press_nxt_s  = 1'b0;
        short_nxt_s  = 1'b0;
        long_nxt_s   = 1'b0;
        hold_nxt_s   = 1'b0;
        repeat_nxt_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (press_edge_s) begin
                    state_nxt_s = ST_PRESSED;
                    press_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_PRESSED: begin
                if (btn_n) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    short_nxt_s = 1'b1;
                end else if (cnt_r == LONG_LAST) begin
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = CNT_ZERO;
                    long_nxt_s  = 1'b1;
                    hold_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_PRESSED;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end

            ST_HELD: begin
                if (btn_n) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                    hold_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = ST_HELD;
                    hold_nxt_s  = 1'b1;
`ifdef BUTTON_REPEAT_EN
                    if (cnt_r == REPEAT_LAST) begin
                        cnt_nxt_s    = CNT_ZERO;
                        repeat_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s    = cnt_r + CNT_ONE;
                    end
`else
                    if (cnt_r != CNT_MAX) begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
`endif
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered event outputs; reset forces IDLE with all outputs low
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            press_r  <= 1'b0;
            short_r  <= 1'b0;
            long_r   <= 1'b0;
            hold_r   <= 1'b0;
            repeat_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            press_r  <= press_nxt_s;
            short_r  <= short_nxt_s;
            long_r   <= long_nxt_s;
            hold_r   <= hold_nxt_s;
            repeat_r <= repeat_nxt_s;
        end
    end

    assign press_pulse  = press_r;
    assign short_pulse  = short_r;
    assign long_pulse   = long_r;
    assign hold_level   = hold_r;
    assign repeat_pulse = repeat_r;

endmodule
